nibble_serial_adder: RTL and testbench



---
 rtl/nibble_serial_adder_if.sv | 25 ++
 rtl/nibble_serial_adder.sv | 114 +++++++++++
 tb/tb_nibble_serial_adder.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if: operand/result handshake bundle for the nibble-serial adder
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add done one nibble per clock through a single 4-bit CLA slice
module carry_look_ahead_adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g    = A & B;
    assign p    = A ^ B;
    assign c[0] = Cin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);
    assign Sum  = p ^ c[3:0];
    assign Cout = c[4];
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    nibble_serial_adder_if.slave bus
);
    localparam int N  = WIDTH / 4;
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             msb_a;
    logic             msb_b;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [3:0]       nib_sum;
    logic             nib_cout;

    carry_look_ahead_adder slice (
        .A    (opa[3:0]),
        .B    (opb[3:0]),
        .Cin  (carry),
        .Sum  (nib_sum),
        .Cout (nib_cout)
    );

    // Sequencer: accept operands, walk the nibbles LSB first through the slice, hold the result until taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            opa         <= '0;
            opb         <= '0;
            res         <= '0;
            carry       <= 1'b0;
            cnt         <= '0;
            msb_a       <= 1'b0;
            msb_b       <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_r <= 1'b1;
                    if (bus.in_valid && in_ready_r) begin
                        opa        <= bus.a;
                        opb        <= bus.b;
                        carry      <= bus.cin;
                        cnt        <= '0;
                        msb_a      <= bus.a[WIDTH-1];
                        msb_b      <= bus.b[WIDTH-1];
                        in_ready_r <= 1'b0;
                        state      <= ADD;
                    end
                end
                ADD: begin
                    res   <= {nib_sum, res[WIDTH-1:4]};
                    opa   <= opa >> 4;
                    opb   <= opb >> 4;
                    carry <= nib_cout;
                    cnt   <= (cnt == CW'(N - 1)) ? '0 : cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = res;
    assign bus.cout      = carry;
    assign bus.overflow  = out_valid_r & (msb_a == msb_b) & (res[WIDTH-1] != msb_a);
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed and random checks of 16- and 32-bit nibble-serial adders
module tb_nibble_serial_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        cin = 1'b0;
    logic        out_ready = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] got_sum;
    logic        got_cout;
    logic        got_ovf;
    logic        o_ready, o_valid, o_cout, o_ovf;
    logic [31:0] o_sum;

    nibble_serial_adder_if #(.WIDTH(16)) bus16 ();
    nibble_serial_adder_if #(.WIDTH(32)) bus32 ();

    nibble_serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    nibble_serial_adder #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    assign bus16.in_valid  = in_valid & ~sel;
    assign bus16.a         = a[15:0];
    assign bus16.b         = b[15:0];
    assign bus16.cin       = cin;
    assign bus16.out_ready = out_ready;
    assign bus32.in_valid  = in_valid & sel;
    assign bus32.a         = a;
    assign bus32.b         = b;
    assign bus32.cin       = cin;
    assign bus32.out_ready = out_ready;

    assign o_ready = sel ? bus32.in_ready : bus16.in_ready;
    assign o_valid = sel ? bus32.out_valid : bus16.out_valid;
    assign o_sum   = sel ? bus32.sum : {16'd0, bus16.sum};
    assign o_cout  = sel ? bus32.cout : bus16.cout;
    assign o_ovf   = sel ? bus32.overflow : bus16.overflow;

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction on the selected width, checked against plain integer arithmetic
    task automatic do_op(input int w, input logic [31:0] va, input logic [31:0] vb,
                         input logic vc, input int gap, input bit noise);
        logic [63:0] mask, t, es;
        logic        ec, eo;
        int          n;
        mask = (64'd1 << w) - 64'd1;
        t    = ({32'd0, va} & mask) + ({32'd0, vb} & mask) + {63'd0, vc};
        es   = t & mask;
        ec   = t[w];
        eo   = (va[w-1] == vb[w-1]) && (es[w-1] != va[w-1]);
        sel       = (w == 32);
        out_ready = (gap == 0);
        n = 0;
        while (o_ready !== 1'b1 && n < 50) begin
            step;
            n++;
        end
        chk("ready_wait", {63'd0, o_ready}, 64'd1);
        a = va;
        b = vb;
        cin = vc;
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        for (int i = 1; i < w / 4; i++) begin
            if (noise) begin
                in_valid = 1'b1;
                a = $urandom;
                b = $urandom;
                cin = 1'($urandom_range(0, 1));
            end
            step;
            chk("busy_ready", {63'd0, o_ready}, 64'd0);
            chk("early_valid", {63'd0, o_valid}, 64'd0);
        end
        step;
        chk("latency_valid", {63'd0, o_valid}, 64'd1);
        chk("sum", {32'd0, o_sum}, es);
        chk("cout", {63'd0, o_cout}, {63'd0, ec});
        chk("overflow", {63'd0, o_ovf}, {63'd0, eo});
        got_sum  = o_sum;
        got_cout = o_cout;
        got_ovf  = o_ovf;
        for (int i = 0; i < gap; i++) begin
            step;
            chk("hold_valid", {63'd0, o_valid}, 64'd1);
            chk("hold_sum", {32'd0, o_sum}, es);
            chk("hold_cout", {63'd0, o_cout}, {63'd0, ec});
            chk("hold_ovf", {63'd0, o_ovf}, {63'd0, eo});
            chk("hold_ready", {63'd0, o_ready}, 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step;
        chk("consumed_valid", {63'd0, o_valid}, 64'd0);
        chk("consumed_ready", {63'd0, o_ready}, 64'd1);
    endtask

    initial begin
        step;
        step;
        chk("rst_ready16", {63'd0, bus16.in_ready}, 64'd0);
        chk("rst_valid16", {63'd0, bus16.out_valid}, 64'd0);
        chk("rst_sum16", {48'd0, bus16.sum}, 64'd0);
        chk("rst_cout16", {63'd0, bus16.cout}, 64'd0);
        chk("rst_ovf16", {63'd0, bus16.overflow}, 64'd0);
        chk("rst_ready32", {63'd0, bus32.in_ready}, 64'd0);
        chk("rst_valid32", {63'd0, bus32.out_valid}, 64'd0);
        rst_n = 1'b1;
        step;
        chk("rel_ready16", {63'd0, bus16.in_ready}, 64'd1);
        chk("rel_ready32", {63'd0, bus32.in_ready}, 64'd1);

        do_op(16, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0);
        chk("ffff_sum", {32'd0, got_sum}, 64'h0000);
        chk("ffff_cout", {63'd0, got_cout}, 64'd1);
        chk("ffff_ovf", {63'd0, got_ovf}, 64'd0);
        do_op(16, 32'h0000_7FFF, 32'h0000_0001, 1'b0, 0, 1'b0);
        chk("7fff_sum", {32'd0, got_sum}, 64'h8000);
        chk("7fff_cout", {63'd0, got_cout}, 64'd0);
        chk("7fff_ovf", {63'd0, got_ovf}, 64'd1);
        do_op(16, 32'h0000_8000, 32'h0000_8000, 1'b0, 0, 1'b0);
        chk("8000_sum", {32'd0, got_sum}, 64'h0000);
        chk("8000_cout", {63'd0, got_cout}, 64'd1);
        chk("8000_ovf", {63'd0, got_ovf}, 64'd1);
        do_op(16, 32'h0000_1234, 32'h0000_4321, 1'b1, 0, 1'b1);
        chk("noise_sum", {32'd0, got_sum}, 64'h5556);
        chk("noise_cout", {63'd0, got_cout}, 64'd0);
        do_op(16, 32'h0000_ABCD, 32'h0000_1111, 1'b0, 10, 1'b0);
        chk("bp_sum", {32'd0, got_sum}, 64'hBCDE);
        do_op(32, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0);
        chk("w32_sum", {32'd0, got_sum}, 64'h0);
        chk("w32_cout", {63'd0, got_cout}, 64'd1);

        sel = 1'b0;
        a = 32'h1234;
        b = 32'h1111;
        cin = 1'b0;
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        step;
        rst_n = 1'b0;
        step;
        chk("mid_rst_valid", {63'd0, o_valid}, 64'd0);
        chk("mid_rst_sum", {32'd0, o_sum}, 64'd0);
        chk("mid_rst_cout", {63'd0, o_cout}, 64'd0);
        chk("mid_rst_ovf", {63'd0, o_ovf}, 64'd0);
        chk("mid_rst_ready", {63'd0, o_ready}, 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step;
            chk("no_result", {63'd0, o_valid}, 64'd0);
        end
        do_op(16, 32'h0000_00FF, 32'h0000_0001, 1'b0, 0, 1'b0);
        chk("after_rst_sum", {32'd0, got_sum}, 64'h0100);

        for (int i = 0; i < 1000; i++)
            do_op(16, $urandom, $urandom, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                  $urandom_range(0, 7) == 0);
        for (int i = 0; i < 1000; i++)
            do_op(32, $urandom, $urandom, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                  $urandom_range(0, 7) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
